// File: rtl/axis_pkt_offset_add_if.sv
// AXI-Stream beat bundle used on both sides of the packet offset-add stage.
interface axis_pkt_offset_add_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_pkt_offset_add.sv
// Ping-pong packet buffer producing out[i] = in[i] + in[i+k] within each packet.
// Beat 0 of a just-closing packet bypasses from the input so output starts one cycle later.
module axis_pkt_offset_add #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned LW      = $clog2(DEPTH + 1),
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_pkt_offset_add_if.slave  s_axis,
  axis_pkt_offset_add_if.master m_axis,
  input  logic [LW-1:0]         cfg_len,
  input  logic [LW-1:0]         cfg_k,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic [1:0] {BkEmpty, BkFill, BkReady, BkDrain} bank_st_e;

  bank_st_e          st_q  [2];
  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [LW-1:0]     len_q [2];
  logic [LW-1:0]     k_q   [2];
  logic              wsel_q, rsel_q;
  logic [LW-1:0]     wr_idx_q, rd_idx_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q, m_last_q;

  logic              s_ready, s_hs, first, close, mlast_hs, cand;
  logic              ld, byp, ld_bank, pair, res_last;
  logic [LW-1:0]     len_norm, cur_len, cur_k, ld_idx, ld_n, ld_k;
  logic [31:0]       idx_sum;
  logic [AW-1:0]     ja, jb;
  logic [DATA_W-1:0] opa, opb, res;
  logic [DATA_W:0]   sum;

  assign s_ready  = !rst && (st_q[wsel_q] == BkEmpty || st_q[wsel_q] == BkFill);
  assign s_hs     = s_axis.valid && s_ready;
  assign first    = (st_q[wsel_q] == BkEmpty);
  assign len_norm = (cfg_len == '0 || 32'(cfg_len) > DEPTH) ? LW'(DEPTH) : cfg_len;
  assign cur_len  = first ? len_norm : len_q[wsel_q];
  assign cur_k    = first ? cfg_k : k_q[wsel_q];
  assign close    = s_hs && (s_axis.last || (wr_idx_q + LW'(1)) == cur_len);
  assign mlast_hs = m_valid_q && m_axis.ready && m_last_q;
  // Once the draining bank hands off its last beat, the other bank may start this same cycle.
  assign cand     = mlast_hs ? !rsel_q : rsel_q;

  always_comb begin
    ld      = 1'b0;
    byp     = 1'b0;
    ld_bank = rsel_q;
    ld_idx  = rd_idx_q;
    ld_n    = len_q[rsel_q];
    ld_k    = k_q[rsel_q];
    if (!m_valid_q || m_axis.ready) begin
      if (!mlast_hs && st_q[rsel_q] == BkDrain && rd_idx_q < len_q[rsel_q]) begin
        ld = 1'b1;
      end else if (st_q[cand] == BkReady) begin
        ld      = 1'b1;
        ld_bank = cand;
        ld_idx  = '0;
        ld_n    = len_q[cand];
        ld_k    = k_q[cand];
      end else if (cand == wsel_q && close) begin
        ld      = 1'b1;
        byp     = 1'b1;
        ld_bank = cand;
        ld_idx  = '0;
        ld_n    = wr_idx_q + LW'(1);
        ld_k    = cur_k;
      end
    end
    idx_sum  = 32'(ld_idx) + 32'(ld_k);
    pair     = idx_sum < 32'(ld_n);
    ja       = AW'(ld_idx);
    jb       = pair ? AW'(idx_sum) : ja;
    opa      = (byp && ld_idx == wr_idx_q) ? s_axis.data : mem_q[ld_bank][ja];
    opb      = (byp && idx_sum == 32'(wr_idx_q)) ? s_axis.data : mem_q[ld_bank][jb];
    sum      = {1'b0, opa} + (pair ? {1'b0, opb} : '0);
    res      = (SATURATE && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
    res_last = (ld_idx + LW'(1)) == ld_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= BkEmpty;
        len_q[b] <= '0;
        k_q[b]   <= '0;
      end
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (s_hs) begin
        mem_q[wsel_q][AW'(wr_idx_q)] <= s_axis.data;
        if (first) begin
          st_q[wsel_q]  <= BkFill;
          len_q[wsel_q] <= len_norm;
          k_q[wsel_q]   <= cfg_k;
        end
        if (close) begin
          // Stored length becomes the effective length so an early s_last shortens the packet.
          st_q[wsel_q]  <= BkReady;
          len_q[wsel_q] <= wr_idx_q + LW'(1);
          wsel_q        <= !wsel_q;
          wr_idx_q      <= '0;
        end else begin
          wr_idx_q <= wr_idx_q + LW'(1);
        end
      end
      if (mlast_hs) begin
        st_q[rsel_q] <= BkEmpty;
        rsel_q       <= !rsel_q;
      end
      if (ld) begin
        if (ld_idx == '0) st_q[ld_bank] <= BkDrain;
        rd_idx_q  <= ld_idx + LW'(1);
        m_data_q  <= res;
        m_last_q  <= res_last;
        m_valid_q <= 1'b1;
      end else if (m_axis.ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign s_axis.ready = s_ready;
  assign m_axis.data  = m_data_q;
  assign m_axis.valid = m_valid_q;
  assign m_axis.last  = m_last_q;
  assign full         = !rst && !s_ready;
  assign empty        = (st_q[0] == BkEmpty) && (st_q[1] == BkEmpty) && !m_valid_q;

endmodule

// File: tb/tb_axis_pkt_offset_add.sv
// Scoreboard bench: a wrapping and a saturating instance see identical stimulus.
module tb_axis_pkt_offset_add;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, m_ready;
  logic [LW-1:0] cfg_len, cfg_k;
  logic          full0, empty0, full1, empty1;

  always #5 clk = ~clk;

  axis_pkt_offset_add_if #(.DATA_W(DW)) s0 ();
  axis_pkt_offset_add_if #(.DATA_W(DW)) s1 ();
  axis_pkt_offset_add_if #(.DATA_W(DW)) m0 ();
  axis_pkt_offset_add_if #(.DATA_W(DW)) m1 ();

  assign s0.data  = s_data;
  assign s0.valid = s_valid;
  assign s0.last  = s_last;
  assign s1.data  = s_data;
  assign s1.valid = s_valid;
  assign s1.last  = s_last;
  assign m0.ready = m_ready;
  assign m1.ready = m_ready;

  axis_pkt_offset_add #(.DATA_W(DW), .DEPTH(DEPTH), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .s_axis(s0.slave), .m_axis(m0.master),
    .cfg_len(cfg_len), .cfg_k(cfg_k), .full(full0), .empty(empty0)
  );

  axis_pkt_offset_add #(.DATA_W(DW), .DEPTH(DEPTH), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .s_axis(s1.slave), .m_axis(m1.master),
    .cfg_len(cfg_len), .cfg_k(cfg_k), .full(full1), .empty(empty1)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         pd[$];
  int         ew[$];
  int         es[$];
  bit         rnd_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented beat with the queue head every cycle; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0.valid) begin
        if (q0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wrap beat: got 0x%0h, expected no beat", {m0.last, m0.data});
        end else begin
          chk("wrap beat", 32'({m0.last, m0.data}), 32'(q0[0]));
          if (m_ready) void'(q0.pop_front());
        end
      end
      if (m1.valid) begin
        if (q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sat beat: got 0x%0h, expected no beat", {m1.last, m1.data});
        end else begin
          chk("sat beat", 32'({m1.last, m1.data}), 32'(q1[0]));
          if (m_ready) void'(q1.pop_front());
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (rnd_en) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic push_exp();
    for (int i = 0; i < ew.size(); i++) begin
      q0.push_back({i == ew.size() - 1, 8'(ew[i])});
      q1.push_back({i == es.size() - 1, 8'(es[i])});
    end
  endtask

  task automatic model_exp(input int k);
    int n, s;
    n = pd.size();
    ew.delete();
    es.delete();
    for (int i = 0; i < n; i++) begin
      s = pd[i] + ((i + k < n) ? pd[i + k] : 0);
      ew.push_back(s % 256);
      es.push_back((s > 255) ? 255 : s);
    end
    push_exp();
  endtask

  // Drives pd[] as one packet; cfg is scrambled after every accepted beat.
  task automatic send(input int cl, input int ck, input bit use_last);
    int n, t;
    n       = pd.size();
    cfg_len = LW'(cl);
    cfg_k   = LW'(ck);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(pd[i]);
      s_last  = use_last && (i == n - 1);
      t = 0;
      while (!s0.ready && t < 2000) begin
        tick();
        t++;
      end
      if (t >= 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL send: s_ready stuck at 0, expected 1 within 2000 cycles");
        s_valid = 1'b0;
        return;
      end
      tick();
      cfg_len = LW'($urandom);
      cfg_k   = LW'($urandom);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 1000) begin
      tick();
      t++;
    end
    chk("drain pending beats", 32'(q0.size() + q1.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cl, ck, ln, n;
    bit early, ul;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; cfg_len = '0; cfg_k = '0; m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst m_valid", 32'(m0.valid), 0);
    chk("rst m_last", 32'(m0.last), 0);
    chk("rst m_data", 32'(m0.data), 0);
    chk("rst full", 32'(full0), 0);
    chk("rst empty", 32'(empty0), 1);
    chk("rst s_ready", 32'(s0.ready), 0);
    rst = 1'b0;
    #1;
    chk("s_ready after rst", 32'(s0.ready), 1);

    // Basic k=1 packet and one-cycle latency.
    pd = '{10, 20, 30, 40}; ew = '{30, 50, 70, 40}; es = '{30, 50, 70, 40};
    push_exp();
    chk("t1 idle m_valid", 32'(m0.valid), 0);
    send(4, 1, 1'b1);
    chk("t1 latency m_valid", 32'(m0.valid), 1);
    chk("t1 beat0 m_last", 32'(m0.last), 0);
    wait_drain();
    chk("t1 empty", 32'(empty0), 1);

    // Wrap versus saturate.
    pd = '{200, 100}; ew = '{44, 100}; es = '{255, 100};
    push_exp();
    send(2, 1, 1'b1);
    pd = '{200}; ew = '{144}; es = '{255};
    push_exp();
    send(1, 0, 1'b0);
    wait_drain();

    // Early s_last, then close on length without s_last.
    pd = '{1, 2, 3}; ew = '{4, 2, 3}; es = '{4, 2, 3};
    push_exp();
    send(8, 2, 1'b1);
    pd = '{5, 6, 7}; ew = '{10, 12, 14}; es = '{10, 12, 14};
    push_exp();
    send(3, 0, 1'b0);
    wait_drain();

    // k beyond length is passthrough; cfg_len=0 means DEPTH.
    pd = '{1, 2, 3, 4}; ew = '{1, 2, 3, 4}; es = '{1, 2, 3, 4};
    push_exp();
    send(4, 5, 1'b1);
    pd = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    ew = '{17, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    es = ew;
    push_exp();
    send(0, 15, 1'b0);
    wait_drain();

    // Backpressure: two banks fill, third packet stalls, then back-to-back drain.
    m_ready = 1'b0;
    pd = '{1, 2, 3, 4}; ew = '{3, 5, 7, 4}; es = '{3, 5, 7, 4};
    push_exp();
    send(4, 1, 1'b1);
    pd = '{10, 20, 30, 40}; ew = '{40, 60, 30, 40}; es = '{40, 60, 30, 40};
    push_exp();
    send(4, 2, 1'b1);
    chk("t4 s_ready stalled", 32'(s0.ready), 0);
    chk("t4 full", 32'(full0), 1);
    chk("t4 sat full", 32'(full1), 1);
    pd = '{5, 6, 7, 8}; ew = '{13, 6, 7, 8}; es = '{13, 6, 7, 8};
    push_exp();
    fork
      send(4, 3, 1'b1);
    join_none
    repeat (5) tick();
    chk("t4 third packet stalled", 32'(s0.ready), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4 no bubble", 32'(m0.valid), 1);
      tick();
    end
    wait fork;
    wait_drain();
    chk("t4 full released", 32'(full0), 0);
    chk("t4 empty", 32'(empty0), 1);

    // Random m_ready over 50 packets against the array model.
    rnd_en = 1'b1;
    for (int p = 0; p < 50; p++) begin
      cl    = $urandom_range(0, 20);
      ln    = (cl == 0 || cl > 16) ? 16 : cl;
      ck    = $urandom_range(0, 18);
      early = ($urandom_range(0, 2) == 0);
      n     = early ? $urandom_range(1, ln) : ln;
      ul    = early ? 1'b1 : 1'($urandom_range(0, 1));
      pd.delete();
      for (int i = 0; i < n; i++) pd.push_back($urandom_range(0, 255));
      model_exp(ck);
      send(cl, ck, ul);
    end
    rnd_en = 1'b0;
    tick();
    m_ready = 1'b1;
    wait_drain();

    // Reset while the second beat of a drain is presented.
    pd = '{10, 20, 30, 40}; ew = '{30, 50, 70, 40}; es = '{30, 50, 70, 40};
    push_exp();
    send(4, 1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid rst m_valid", 32'(m0.valid), 0);
    chk("mid rst empty", 32'(empty0), 1);
    chk("mid rst s_ready", 32'(s0.ready), 0);
    q0.delete();
    q1.delete();
    rst = 1'b0;
    #1;
    chk("post rst s_ready", 32'(s0.ready), 1);
    pd = '{5, 6}; ew = '{11, 6}; es = '{11, 6};
    push_exp();
    send(2, 1, 1'b1);
    wait_drain();
    chk("final empty", 32'(empty1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
